seq_divmod: RTL and testbench
=============================

Name: seq_divmod

Overview:
- Parametrised multi-cycle integer divider producing quotient and remainder together.
- Successor to the single-cycle combinational modulo path in ALU.
- Generalised in width, adds signed/unsigned mode, and uses valid/ready handshakes on both sides.
- Sits beside ALU. The execute stage dispatches div/mod ops to it and stalls on in_ready/out_valid.

Parameters:
- WIDTH, 16, operand/result width in bits (>= 2).
- CNT_W, $clog2(WIDTH+1), iteration counter width; derived, not overridden.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operands presented.
- in_ready  output  1  block can accept operands.
- signed_mode  input  1  1: two's-complement operands; 0: unsigned. Sampled on accept.
- lhs  input  WIDTH  dividend, sampled on accept.
- rhs  input  WIDTH  divisor, sampled on accept.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- quotient  output  WIDTH  lhs / rhs, truncated toward zero.
- remainder  output  WIDTH  lhs % rhs; sign follows dividend (SystemVerilog % semantics).
- div_zero  output  1  divisor was zero (see Optional Feature).

Behaviour:
- Reset (async assert, sync release): state=IDLE; in_ready=1; out_valid=0; quotient=0; remainder=0; div_zero=0; counter=0.
- States: IDLE, CALC, FIXUP, DONE.
- IDLE:
  - in_ready=1.
  - Accept when in_valid && in_ready.
  - On accept, latch |lhs|, |rhs| (magnitudes when signed_mode, raw otherwise), sign flags and signed_mode.
  - Clear partial remainder; counter=WIDTH; go to CALC.
- CALC:
  - One restoring-division step per cycle: shift {rem,quo} left 1; trial subtract divisor; keep the difference and set quo LSB=1 if no borrow.
  - Counter decrements. At counter==1, go to FIXUP (exactly WIDTH cycles in CALC).
  - Internal trial subtraction is WIDTH+1 bits so MSB-set unsigned divisors work.
- FIXUP:
  - Negate quotient if signed_mode && (sign_lhs ^ sign_rhs).
  - Negate remainder if signed_mode && sign_lhs.
  - Register the outputs; go to DONE.
- DONE:
  - out_valid=1. quotient, remainder and div_zero stable while out_valid && !out_ready.
  - On out_ready, go to IDLE; out_valid falls next edge.
- Latency: accept edge plus WIDTH+1 edges, then out_valid=1. Fixed, operand-independent (apart from the optional early-out).
- in_ready=0 in CALC, FIXUP and DONE. No accept on the edge that completes DONE; next accept is at earliest one cycle after the out_ready handshake.
- Overflow: signed MIN / -1 gives quotient=MIN (wraps), remainder=0. No flag.
- Natural divide-by-zero result (no macro): quotient all ones, remainder=lhs. Signed fixup is still applied, as the algorithm yields.
- Mid-operation reset: aborts immediately; all outputs at reset values; the operation is discarded.
- in_valid while busy is ignored. lhs and rhs may change freely after the accept edge.

Optional Feature:
- Macro: SEQ_DIVMOD_DIV0_TRAP_EN.
- Defined:
  - On accept with rhs==0, skip CALC/FIXUP and go straight to DONE; out_valid rises on the edge after accept.
  - quotient = all ones, remainder = lhs unmodified, div_zero=1.
  - div_zero clears when leaving DONE.
- Undefined:
  - Zero divisor takes the full WIDTH+1 latency with the natural algorithm result.
  - div_zero is tied 0.

Test Plan:
- WIDTH=16, unsigned, 29 / 4, out_ready=1: quotient=7, remainder=1; out_valid exactly 17 edges after accept; in_ready=0 throughout.
- Signed -29 / 4 -> q=-7, r=-1. Signed 29 / -4 -> q=-7, r=1. Signed -29 / -4 -> q=7, r=-1. Unsigned 0xFFE3 / 4 -> q=0x3FF8, r=3.
- Sweep lhs, rhs in 2..29, unsigned and signed, against the SV / and % operators; zero mismatches.
- Signed 0x8000 / 0xFFFF -> q=0x8000, r=0. Unsigned 0xFFFF / 0x8001 -> q=1, r=0x7FFE.
- 100 / 0:
  - Macro on: out_valid 1 edge after accept, q=0xFFFF, r=100, div_zero=1.
  - Macro off: 17 edges, div_zero=0.
- Hold out_ready=0 for 5 cycles after out_valid: outputs stable, in_ready=0. Assert rst at CALC cycle 8: out_valid=0 and in_ready=1 immediately, next op correct.

Source files
------------

// File: rtl/seq_divmod.sv
// Multi-cycle restoring divider producing quotient and remainder, signed or unsigned.
// Define SEQ_DIVMOD_DIV0_TRAP_EN to short-circuit zero divisors with a div_zero flag.
module seq_divmod #(
    parameter int WIDTH = 16,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] lhs,
    input  logic [WIDTH-1:0] rhs,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic             neg_quo;
    logic             neg_rem;
    logic             accept;
    logic             trap_hit;

    logic [WIDTH:0]   shifted;
    logic             no_borrow;
    logic [WIDTH-1:0] rem_next;

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic n);
        return n ? (~v + 1'b1) : v;
    endfunction

    assign accept = (state == IDLE) && in_valid && in_ready;

`ifdef SEQ_DIVMOD_DIV0_TRAP_EN
    assign trap_hit = (rhs == '0);
`else
    assign trap_hit = 1'b0;
`endif

    // One restoring step: the shifted remainder is WIDTH+1 bits so divisors with MSB set still compare correctly.
    assign shifted   = {rem, quo[WIDTH-1]};
    assign no_borrow = (shifted >= {1'b0, dvs});
    assign rem_next  = no_borrow ? (shifted[WIDTH-1:0] - dvs) : shifted[WIDTH-1:0];

    // Working datapath registers carry no reset; control decides when they are meaningful.
    always_ff @(posedge clk) begin
        if (accept) begin
            neg_quo <= signed_mode & (lhs[WIDTH-1] ^ rhs[WIDTH-1]);
            neg_rem <= signed_mode & lhs[WIDTH-1];
            quo     <= cond_neg(lhs, signed_mode & lhs[WIDTH-1]);
            dvs     <= cond_neg(rhs, signed_mode & rhs[WIDTH-1]);
            rem     <= '0;
        end else if (state == CALC) begin
            rem <= rem_next;
            quo <= {quo[WIDTH-2:0], no_borrow};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        in_ready <= 1'b0;
                        if (trap_hit) begin
                            // Results latched now; out_valid rises on the following edge in DONE.
                            quotient  <= '1;
                            remainder <= lhs;
                            div_zero  <= 1'b1;
                            state     <= DONE;
                        end else begin
                            cnt   <= CNT_W'(WIDTH);
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) state <= FIXUP;
                end
                FIXUP: begin
                    quotient  <= cond_neg(quo, neg_quo);
                    remainder <= cond_neg(rem, neg_rem);
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        div_zero  <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divmod.sv
// Self-checking bench for seq_divmod (WIDTH=16) against an arithmetic reference model.
module tb_seq_divmod;

    localparam int W = 16;
`ifdef SEQ_DIVMOD_DIV0_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    localparam int LAT = W + 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic         signed_mode;
    logic [W-1:0] lhs;
    logic [W-1:0] rhs;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_zero;

    int total = 0;
    int passed = 0;

    seq_divmod #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .signed_mode(signed_mode), .lhs(lhs), .rhs(rhs),
        .out_valid(out_valid), .out_ready(out_ready),
        .quotient(quotient), .remainder(remainder), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    // Reference: plain integer division on 32-bit ints, truncating toward zero.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input bit sm,
                         output logic [W-1:0] q, output logic [W-1:0] r, output logic dz);
        int sa, sb;
        dz = 1'b0;
        if (b == '0) begin
            q  = '1;
            r  = a;
            dz = TRAP;
            if (!TRAP && sm && a[W-1]) q = 16'd1;
        end else begin
            if (sm) begin
                sa = int'($signed(a));
                sb = int'($signed(b));
            end else begin
                sa = int'(a);
                sb = int'(b);
            end
            q = W'(sa / sb);
            r = W'(sa % sb);
        end
    endtask

    function automatic int exp_lat(input logic [W-1:0] b);
        return (TRAP && b == '0) ? 1 : LAT;
    endfunction

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit sm,
                         output logic [W-1:0] q, output logic [W-1:0] r, output logic dz,
                         output int lat, output bit rdy_bad);
        int guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b1; lhs = a; rhs = b; signed_mode = sm;
        @(posedge clk); #1;
        in_valid = 1'b0; lhs = W'($urandom); rhs = W'($urandom); signed_mode = 1'($urandom);
        lat = 0; rdy_bad = 1'b0;
        while (!out_valid && lat < 100) begin
            if (in_ready) rdy_bad = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        if (in_ready) rdy_bad = 1'b1;
        q = quotient; r = remainder; dz = div_zero;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; signed_mode = 1'b0; lhs = '0; rhs = '0;
        #12;
        total++;
        if ({in_ready, out_valid, quotient, remainder, div_zero} !== {1'b1, 1'b0, 16'h0, 16'h0, 1'b0})
            $display("FAIL reset_state: got rdy=%b vld=%b q=%h r=%h dz=%b, want 1 0 0000 0000 0",
                     in_ready, out_valid, quotient, remainder, div_zero);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed;
        logic [W-1:0] ta [7] = '{16'd29, 16'hFFE3, 16'd29, 16'hFFE3, 16'hFFE3, 16'h8000, 16'hFFFF};
        logic [W-1:0] tb [7] = '{16'd4, 16'd4, 16'hFFFC, 16'hFFFC, 16'd4, 16'hFFFF, 16'h8001};
        bit           ts [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [W-1:0] eq [7] = '{16'd7, 16'hFFF9, 16'hFFF9, 16'd7, 16'h3FF8, 16'h8000, 16'd1};
        logic [W-1:0] er [7] = '{16'd1, 16'hFFFF, 16'd1, 16'hFFFF, 16'd3, 16'd0, 16'h7FFE};
        logic [W-1:0] q, r;
        logic dz;
        int lat;
        bit rb;
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            do_op(ta[i], tb[i], ts[i], q, r, dz, lat, rb);
            total++;
            if (q !== eq[i] || r !== er[i] || dz !== 1'b0)
                $display("FAIL directed_%0d: got q=%h r=%h dz=%b, want q=%h r=%h dz=0", i, q, r, dz, eq[i], er[i]);
            else passed++;
            total++;
            if (lat !== LAT || rb)
                $display("FAIL directed_timing_%0d: got latency=%0d in_ready_seen=%b, want %0d and 0", i, lat, rb, LAT);
            else passed++;
        end
    endtask

    task automatic test_sweep;
        logic [W-1:0] a, b, q, r, mq, mr;
        logic dz, mdz;
        int lat, bad;
        bit rb;
        out_ready = 1'b1;
        for (int sm = 0; sm < 2; sm++) begin
            bad = 0;
            for (int x = 2; x <= 29; x++) begin
                for (int y = 2; y <= 29; y++) begin
                    a = W'(x); b = W'(y);
                    if (sm == 1 && ((x + y) % 4) >= 2) a = -a;
                    if (sm == 1 && (x % 2) == 1) b = -b;
                    model(a, b, sm[0], mq, mr, mdz);
                    do_op(a, b, sm[0], q, r, dz, lat, rb);
                    if (q !== mq || r !== mr || lat !== LAT) begin
                        if (bad < 5)
                            $display("FAIL sweep_detail sm=%0d %h/%h: got q=%h r=%h lat=%0d, want q=%h r=%h lat=%0d",
                                     sm, a, b, q, r, lat, mq, mr, LAT);
                        bad++;
                    end
                end
            end
            total++;
            if (bad !== 0) $display("FAIL sweep_sm%0d: got %0d bad results, want 0", sm, bad);
            else passed++;
        end
    endtask

    task automatic test_div_zero;
        logic [W-1:0] q, r, mq, mr;
        logic dz, mdz;
        int lat;
        bit rb;
        out_ready = 1'b1;
        for (int sm = 0; sm < 2; sm++) begin
            model(16'd100, 16'd0, sm[0], mq, mr, mdz);
            do_op(16'd100, 16'd0, sm[0], q, r, dz, lat, rb);
            total++;
            if (q !== 16'hFFFF || r !== 16'd100 || dz !== mdz)
                $display("FAIL div0_result_sm%0d: got q=%h r=%h dz=%b, want q=ffff r=0064 dz=%b", sm, q, r, dz, mdz);
            else passed++;
            total++;
            if (lat !== exp_lat(16'd0))
                $display("FAIL div0_latency_sm%0d: got %0d, want %0d", sm, lat, exp_lat(16'd0));
            else passed++;
        end
        model(16'hFF9C, 16'd0, 1'b1, mq, mr, mdz);
        do_op(16'hFF9C, 16'd0, 1'b1, q, r, dz, lat, rb);
        total++;
        if (q !== mq || r !== mr || dz !== mdz)
            $display("FAIL div0_signed_neg: got q=%h r=%h dz=%b, want q=%h r=%h dz=%b", q, r, dz, mq, mr, mdz);
        else passed++;
        @(posedge clk); #1;
        total++;
        if (div_zero !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL div0_clear: got dz=%b vld=%b, want 0 0", div_zero, out_valid);
        else passed++;
    endtask

    task automatic test_backpressure;
        logic [W-1:0] q, r;
        logic dz;
        int lat, bad;
        bit rb;
        out_ready = 1'b0;
        do_op(16'd1234, 16'd10, 1'b0, q, r, dz, lat, rb);
        total++;
        if (q !== 16'd123 || r !== 16'd4)
            $display("FAIL backpressure_result: got q=%0d r=%0d, want 123 4", q, r);
        else passed++;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== 16'd123 || remainder !== 16'd4) bad++;
        end
        total++;
        if (bad !== 0) $display("FAIL backpressure_hold: got %0d unstable cycles, want 0", bad);
        else passed++;
        out_ready = 1'b1;
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL backpressure_release: got vld=%b rdy=%b, want 0 1", out_valid, in_ready);
        else passed++;
    endtask

    task automatic test_mid_reset;
        logic [W-1:0] q, r;
        logic dz;
        int lat;
        bit rb;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; lhs = 16'd5000; rhs = 16'd3; signed_mode = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || quotient !== 16'h0 || remainder !== 16'h0)
            $display("FAIL mid_reset: got vld=%b rdy=%b q=%h r=%h, want 0 1 0000 0000", out_valid, in_ready, quotient, remainder);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        do_op(16'd1000, 16'd7, 1'b0, q, r, dz, lat, rb);
        total++;
        if (q !== 16'd142 || r !== 16'd6 || lat !== LAT)
            $display("FAIL after_reset_op: got q=%0d r=%0d lat=%0d, want 142 6 %0d", q, r, lat, LAT);
        else passed++;
    endtask

    task automatic test_random;
        logic [W-1:0] a, b, q, r, mq, mr;
        logic dz, mdz;
        int lat, bad;
        bit rb, sm;
        bad = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            a = W'($urandom);
            b = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 20)) : W'($urandom);
            sm = 1'($urandom);
            model(a, b, sm, mq, mr, mdz);
            do_op(a, b, sm, q, r, dz, lat, rb);
            if (q !== mq || r !== mr || dz !== mdz || lat !== exp_lat(b) || rb) begin
                if (bad < 5)
                    $display("FAIL random_detail sm=%0d %h/%h: got q=%h r=%h dz=%b lat=%0d, want q=%h r=%h dz=%b lat=%0d",
                             sm, a, b, q, r, dz, lat, mq, mr, mdz, exp_lat(b));
                bad++;
            end
        end
        total++;
        if (bad !== 0) $display("FAIL random: got %0d bad results, want 0", bad);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_sweep();
        test_div_zero();
        test_backpressure();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
